// File: rtl/line_matrix_3x3_gen.sv
// 3x3 neighbourhood generator: two line memories plus per-row shift taps; pixel/syncs out 2 clocks later, no backpressure.
// Optional build macro MATRIX_BORDER_ZERO_EN zeroes taps outside the frame and marks every window valid.
module line_matrix_3x3_gen #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  pre_vsync,
    input  logic                  pre_href,
    input  logic                  pre_clken,
    input  logic [DATA_WIDTH-1:0] pre_data,
    output logic                  post_vsync,
    output logic                  post_href,
    output logic                  post_clken,
    output logic                  post_win_valid,
    output logic [DATA_WIDTH-1:0] m11,
    output logic [DATA_WIDTH-1:0] m12,
    output logic [DATA_WIDTH-1:0] m13,
    output logic [DATA_WIDTH-1:0] m21,
    output logic [DATA_WIDTH-1:0] m22,
    output logic [DATA_WIDTH-1:0] m23,
    output logic [DATA_WIDTH-1:0] m31,
    output logic [DATA_WIDTH-1:0] m32,
    output logic [DATA_WIDTH-1:0] m33
);
    localparam int CW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int RW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP - 1);

    logic [DATA_WIDTH-1:0] r_mem0 [0:IMG_HDISP-1];
    logic [DATA_WIDTH-1:0] r_mem1 [0:IMG_HDISP-1];

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  r_href_d;
    logic                  r_vsync_d;
    logic                  r_s1_vld;
    logic                  r_s1_win;
    logic [DATA_WIDTH-1:0] r_s1_1;
    logic [DATA_WIDTH-1:0] r_s1_2;
    logic [DATA_WIDTH-1:0] r_s1_3;
    logic                  w_active;
    logic                  w_href_fall;
    logic                  w_win;
    logic [DATA_WIDTH-1:0] w_tap1;
    logic [DATA_WIDTH-1:0] w_tap2;

    assign w_active    = pre_href & pre_clken;
    assign w_href_fall = r_href_d & ~pre_href;

`ifdef MATRIX_BORDER_ZERO_EN
    logic r_s1_col0;
    logic r_s1_col1;
    assign w_tap1 = (r_row < RW'(2)) ? '0 : r_mem1[r_col];
    assign w_tap2 = (r_row == '0)    ? '0 : r_mem0[r_col];
    assign w_win  = 1'b1;
`else
    assign w_tap1 = r_mem1[r_col];
    assign w_tap2 = r_mem0[r_col];
    assign w_win  = (r_row >= RW'(2)) && (r_col >= CW'(2));
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_col    <= '0;
            r_row    <= '0;
            r_href_d <= 1'b0;
        end else begin
            r_href_d <= pre_href;
            if (!pre_vsync) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_href_fall) begin
                r_col <= '0;
                if (r_row != ROW_MAX)
                    r_row <= r_row + RW'(1);
            end else if (w_active) begin
                r_col <= (r_col == COL_MAX) ? '0 : r_col + CW'(1);
            end
        end
    end

    // Line memories are never reset; a location is always written before the window can use it.
    always_ff @(posedge clock) begin
        if (w_active) begin
            r_mem1[r_col] <= r_mem0[r_col];
            r_mem0[r_col] <= pre_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s1_win  <= 1'b0;
            r_s1_1    <= '0;
            r_s1_2    <= '0;
            r_s1_3    <= '0;
`ifdef MATRIX_BORDER_ZERO_EN
            r_s1_col0 <= 1'b0;
            r_s1_col1 <= 1'b0;
`endif
        end else begin
            r_vsync_d <= pre_vsync;
            r_s1_vld  <= w_active;
            if (w_active) begin
                r_s1_1   <= w_tap1;
                r_s1_2   <= w_tap2;
                r_s1_3   <= pre_data;
                r_s1_win <= w_win;
`ifdef MATRIX_BORDER_ZERO_EN
                r_s1_col0 <= (r_col == '0);
                r_s1_col1 <= (r_col == CW'(1));
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            post_vsync     <= 1'b0;
            post_href      <= 1'b0;
            post_clken     <= 1'b0;
            post_win_valid <= 1'b0;
            {m11, m12, m13} <= '0;
            {m21, m22, m23} <= '0;
            {m31, m32, m33} <= '0;
        end else begin
            post_vsync     <= r_vsync_d;
            post_href      <= r_href_d;
            post_clken     <= r_s1_vld;
            post_win_valid <= r_s1_vld & r_s1_win;
            if (r_s1_vld) begin
                m11 <= m12;  m12 <= m13;  m13 <= r_s1_1;
                m21 <= m22;  m22 <= m23;  m23 <= r_s1_2;
                m31 <= m32;  m32 <= m33;  m33 <= r_s1_3;
`ifdef MATRIX_BORDER_ZERO_EN
                // Left columns have no pixels to their left in this line: load zero instead of shifting.
                if (r_s1_col0) begin
                    m11 <= '0;  m12 <= '0;
                    m21 <= '0;  m22 <= '0;
                    m31 <= '0;  m32 <= '0;
                end else if (r_s1_col1) begin
                    m11 <= '0;  m21 <= '0;  m31 <= '0;
                end
`endif
            end
        end
    end
endmodule
